// File: rtl/ysyx_23060236_tlb_assoc_pkg.sv
// rtl/ysyx_23060236_tlb_assoc_pkg.sv - shared defaults and types for the set-associative TLB
//
// Purpose: default geometry of the TLB (VPN width, PPN width, sets, ways) and the
//          performance-counter type, imported by the TLB top and its round-robin helper.
// Ports:   none (package).
package ysyx_23060236_tlb_assoc_pkg;

  localparam int TLB_ADDR_LEN = 20;
  localparam int TLB_DATA_LEN = 20;
  localparam int TLB_SETS     = 4;
  localparam int TLB_WAYS     = 2;

  typedef logic [31:0] tlb_cnt_t;

endpackage

// File: rtl/ysyx_23060236_tlb_rr.sv
// rtl/ysyx_23060236_tlb_rr.sv - per-set round-robin victim pointer array
//
// Purpose: one WAY_LEN-bit pointer per set; the pointer of the addressed set is
//          presented combinationally and advances by one (mod WAYS) on adv_i.
// Ports:
//   clock  in   system clock
//   reset  in   synchronous active-high reset, clears every pointer
//   idx_i  in   set index to read / advance
//   adv_i  in   advance the pointer of set idx_i at the next edge
//   ptr_o  out  current pointer of set idx_i
module ysyx_23060236_tlb_rr
  import ysyx_23060236_tlb_assoc_pkg::*;
#(
  parameter int SETS = TLB_SETS,
  parameter int WAYS = TLB_WAYS,
  localparam int INDEX_LEN = $clog2(SETS),
  localparam int WAY_LEN   = $clog2(WAYS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [INDEX_LEN-1:0] idx_i,
  input  logic                 adv_i,
  output logic [WAY_LEN-1:0]   ptr_o
);

  logic [WAY_LEN-1:0] ptr_q [SETS];

  assign ptr_o = ptr_q[idx_i];

  // WAYS is a power of two, so the natural WAY_LEN-bit overflow is the wrap to 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
    end else if (adv_i) begin
      ptr_q[idx_i] <= ptr_q[idx_i] + 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_23060236_tlb_assoc.sv
// rtl/ysyx_23060236_tlb_assoc.sv - set-associative VPN->PPN TLB with registered lookup
//
// Purpose: maps VPN to PPN. A lookup request is registered; the result (rdone pulse,
//          hit, data) appears the following cycle, computed from the registered query
//          against the current arrays. Refill avoids duplicates, prefers invalid ways,
//          otherwise evicts the per-set round-robin victim. Supports full and
//          single-address flush.
// Optional feature: macro TLB_PERF_EN adds tlb_hit_cnt / tlb_miss_cnt counters.
// Ports:
//   clock, reset                 clock, synchronous active-high reset
//   tlb_araddr, tlb_rvalid       lookup VPN and request
//   tlb_rdone, tlb_hit, tlb_rdata  lookup result pulse, hit flag, PPN (0 on miss)
//   tlb_awaddr, tlb_wdata, tlb_wvalid  refill VPN, PPN, strobe
//   tlb_flush                    invalidate all entries
//   tlb_flush_one, tlb_flush_addr  invalidate entry matching the given VPN
//   tlb_hit_cnt, tlb_miss_cnt    (TLB_PERF_EN) lookup hit / miss counters
module ysyx_23060236_tlb_assoc
  import ysyx_23060236_tlb_assoc_pkg::*;
#(
  parameter int ADDR_LEN = TLB_ADDR_LEN,
  parameter int DATA_LEN = TLB_DATA_LEN,
  parameter int SETS     = TLB_SETS,
  parameter int WAYS     = TLB_WAYS,
  localparam int INDEX_LEN = $clog2(SETS),
  localparam int WAY_LEN   = $clog2(WAYS),
  localparam int TAG_LEN   = ADDR_LEN - INDEX_LEN
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_LEN-1:0] tlb_araddr,
  input  logic                tlb_rvalid,
  output logic                tlb_rdone,
  output logic                tlb_hit,
  output logic [DATA_LEN-1:0] tlb_rdata,
  input  logic [ADDR_LEN-1:0] tlb_awaddr,
  input  logic [DATA_LEN-1:0] tlb_wdata,
  input  logic                tlb_wvalid,
  input  logic                tlb_flush,
  input  logic                tlb_flush_one,
  input  logic [ADDR_LEN-1:0] tlb_flush_addr
`ifdef TLB_PERF_EN
  ,
  output logic [31:0]         tlb_hit_cnt,
  output logic [31:0]         tlb_miss_cnt
`endif
);

  logic [WAYS-1:0]     valid_q [SETS];
  logic [TAG_LEN-1:0]  tag_q   [SETS][WAYS];
  logic [DATA_LEN-1:0] data_q  [SETS][WAYS];

  logic [INDEX_LEN-1:0] q_idx_q;
  logic [TAG_LEN-1:0]   q_tag_q;
  logic                 rdone_q;

  // ---------------- lookup ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      q_idx_q <= '0;
      q_tag_q <= '0;
      rdone_q <= 1'b0;
    end else begin
      rdone_q <= tlb_rvalid;
      if (tlb_rvalid) begin
        q_idx_q <= tlb_araddr[INDEX_LEN-1:0];
        q_tag_q <= tlb_araddr[ADDR_LEN-1:INDEX_LEN];
      end
    end
  end

  logic [WAYS-1:0]     hit_vec;
  logic [DATA_LEN-1:0] hit_data;

  // At most one way can match, so OR-ing matching ways acts as a one-hot mux and
  // yields zero data on a miss without an extra mask.
  always_comb begin
    hit_vec  = '0;
    hit_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[q_idx_q][w] && (tag_q[q_idx_q][w] == q_tag_q)) begin
        hit_vec[w] = 1'b1;
        hit_data   = hit_data | data_q[q_idx_q][w];
      end
    end
  end

  assign tlb_rdone = rdone_q;
  assign tlb_hit   = |hit_vec;
  assign tlb_rdata = hit_data;

  // ---------------- refill way selection ----------------
  logic [INDEX_LEN-1:0] w_idx;
  logic [TAG_LEN-1:0]   w_tag;
  logic                 wr_hit, wr_has_inv;
  logic [WAY_LEN-1:0]   wr_hit_way, wr_inv_way, rr_ptr, wr_way;
  logic                 do_write, rr_adv;

  assign w_idx = tlb_awaddr[INDEX_LEN-1:0];
  assign w_tag = tlb_awaddr[ADDR_LEN-1:INDEX_LEN];

  // Scan downward so the last assignment is the lowest-numbered invalid way.
  always_comb begin
    wr_hit     = 1'b0;
    wr_hit_way = '0;
    wr_has_inv = 1'b0;
    wr_inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w_idx][w]) begin
        wr_has_inv = 1'b1;
        wr_inv_way = WAY_LEN'(w);
      end
      if (valid_q[w_idx][w] && (tag_q[w_idx][w] == w_tag)) begin
        wr_hit     = 1'b1;
        wr_hit_way = WAY_LEN'(w);
      end
    end
  end

  // Any flush drops a coincident refill completely, including the pointer update.
  assign do_write = tlb_wvalid && !tlb_flush && !tlb_flush_one;
  assign rr_adv   = do_write && !wr_hit && !wr_has_inv;
  assign wr_way   = wr_hit ? wr_hit_way : (wr_has_inv ? wr_inv_way : rr_ptr);

  ysyx_23060236_tlb_rr #(
    .SETS (SETS),
    .WAYS (WAYS)
  ) u_rr (
    .clock (clock),
    .reset (reset),
    .idx_i (w_idx),
    .adv_i (rr_adv),
    .ptr_o (rr_ptr)
  );

  // ---------------- single-address flush match ----------------
  logic [INDEX_LEN-1:0] f_idx;
  logic [TAG_LEN-1:0]   f_tag;
  logic [WAYS-1:0]      f_vec;

  assign f_idx = tlb_flush_addr[INDEX_LEN-1:0];
  assign f_tag = tlb_flush_addr[ADDR_LEN-1:INDEX_LEN];

  always_comb begin
    f_vec = '0;
    for (int w = 0; w < WAYS; w++) begin
      f_vec[w] = valid_q[f_idx][w] && (tag_q[f_idx][w] == f_tag);
    end
  end

  // ---------------- array update ----------------
  always_ff @(posedge clock) begin
    if (reset || tlb_flush) begin
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else if (tlb_flush_one) begin
      valid_q[f_idx] <= valid_q[f_idx] & ~f_vec;
    end else if (do_write) begin
      valid_q[w_idx][wr_way] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; valid bits gate every use.
  always_ff @(posedge clock) begin
    if (do_write) begin
      tag_q[w_idx][wr_way]  <= w_tag;
      data_q[w_idx][wr_way] <= tlb_wdata;
    end
  end

`ifdef TLB_PERF_EN
  tlb_cnt_t hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (rdone_q) begin
      if (tlb_hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
      else         miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign tlb_hit_cnt  = hit_cnt_q;
  assign tlb_miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_ysyx_23060236_tlb_assoc.sv
// tb/tb_ysyx_23060236_tlb_assoc.sv - directed self-checking bench for the set-associative TLB
module tb_ysyx_23060236_tlb_assoc;

  logic        clock = 1'b0;
  logic        reset;
  logic [19:0] tlb_araddr;
  logic        tlb_rvalid;
  logic        tlb_rdone;
  logic        tlb_hit;
  logic [19:0] tlb_rdata;
  logic [19:0] tlb_awaddr;
  logic [19:0] tlb_wdata;
  logic        tlb_wvalid;
  logic        tlb_flush;
  logic        tlb_flush_one;
  logic [19:0] tlb_flush_addr;
`ifdef TLB_PERF_EN
  logic [31:0] tlb_hit_cnt;
  logic [31:0] tlb_miss_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  ysyx_23060236_tlb_assoc dut (
    .clock          (clock),
    .reset          (reset),
    .tlb_araddr     (tlb_araddr),
    .tlb_rvalid     (tlb_rvalid),
    .tlb_rdone      (tlb_rdone),
    .tlb_hit        (tlb_hit),
    .tlb_rdata      (tlb_rdata),
    .tlb_awaddr     (tlb_awaddr),
    .tlb_wdata      (tlb_wdata),
    .tlb_wvalid     (tlb_wvalid),
    .tlb_flush      (tlb_flush),
    .tlb_flush_one  (tlb_flush_one),
    .tlb_flush_addr (tlb_flush_addr)
`ifdef TLB_PERF_EN
    ,
    .tlb_hit_cnt    (tlb_hit_cnt),
    .tlb_miss_cnt   (tlb_miss_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic do_write(input logic [19:0] addr, input logic [19:0] data);
    @(negedge clock);
    tlb_awaddr = addr;
    tlb_wdata  = data;
    tlb_wvalid = 1'b1;
    @(negedge clock);
    tlb_wvalid = 1'b0;
  endtask

  // Checks rdone/hit/rdata in the cycle after the request.
  task automatic lookup_chk(input string tag, input logic [19:0] addr,
                            input logic exp_hit, input logic [19:0] exp_data);
    @(negedge clock);
    tlb_araddr = addr;
    tlb_rvalid = 1'b1;
    @(negedge clock);
    tlb_rvalid = 1'b0;
    check_eq({tag, "_rdone"}, 32'(tlb_rdone), 32'd1);
    check_eq({tag, "_hit"},   32'(tlb_hit),   32'(exp_hit));
    check_eq({tag, "_rdata"}, 32'(tlb_rdata), 32'(exp_data));
  endtask

  initial begin
    reset = 1'b1;
    tlb_araddr = '0; tlb_rvalid = 1'b0;
    tlb_awaddr = '0; tlb_wdata = '0; tlb_wvalid = 1'b0;
    tlb_flush = 1'b0; tlb_flush_one = 1'b0; tlb_flush_addr = '0;
    do_reset();

    // reset state
    check_eq("rst_rdone", 32'(tlb_rdone), 32'd0);
    check_eq("rst_hit",   32'(tlb_hit),   32'd0);
    check_eq("rst_rdata", 32'(tlb_rdata), 32'd0);

    // empty lookup, then rdone must drop after one cycle
    lookup_chk("empty", 20'h00005, 1'b0, 20'h0);
    @(negedge clock);
    check_eq("rdone_pulse", 32'(tlb_rdone), 32'd0);

    // basic refill and same-set different-tag miss
    do_write(20'h00005, 20'hABCDE);
    lookup_chk("hit5", 20'h00005, 1'b1, 20'hABCDE);
    lookup_chk("miss9", 20'h00009, 1'b0, 20'h0);

    // back-to-back lookups, one result per cycle
    @(negedge clock);
    tlb_araddr = 20'h00005; tlb_rvalid = 1'b1;
    @(negedge clock);
    check_eq("b2b0_rdone", 32'(tlb_rdone), 32'd1);
    check_eq("b2b0_rdata", 32'(tlb_rdata), 32'hABCDE);
    tlb_araddr = 20'h00009;
    @(negedge clock);
    tlb_rvalid = 1'b0;
    check_eq("b2b1_rdone", 32'(tlb_rdone), 32'd1);
    check_eq("b2b1_hit",   32'(tlb_hit),   32'd0);

    // round-robin eviction in set 1
    do_reset();
    do_write(20'h00001, 20'h10001);  // way0
    do_write(20'h00005, 20'h10005);  // way1
    do_write(20'h00009, 20'h10009);  // ptr0 -> way0, ptr=1
    lookup_chk("ev1_1", 20'h00001, 1'b0, 20'h0);
    lookup_chk("ev1_5", 20'h00005, 1'b1, 20'h10005);
    lookup_chk("ev1_9", 20'h00009, 1'b1, 20'h10009);
    do_write(20'h0000D, 20'h1000D);  // ptr1 -> way1, ptr=0
    lookup_chk("ev2_5", 20'h00005, 1'b0, 20'h0);
    lookup_chk("ev2_D", 20'h0000D, 1'b1, 20'h1000D);
    lookup_chk("ev2_9", 20'h00009, 1'b1, 20'h10009);

    // rewrite of present tag: no duplicate, pointer unchanged
    do_reset();
    do_write(20'h00001, 20'h10001);
    do_write(20'h00005, 20'h10005);
    do_write(20'h00005, 20'h11111);
    lookup_chk("rw_5", 20'h00005, 1'b1, 20'h11111);
    lookup_chk("rw_1", 20'h00001, 1'b1, 20'h10001);
    do_write(20'h00009, 20'h10009);  // ptr still 0 -> evicts 0x00001
    lookup_chk("rw_ev1", 20'h00001, 1'b0, 20'h0);
    lookup_chk("rw_ev5", 20'h00005, 1'b1, 20'h11111);

    // flush_one with coincident write: write dropped
    @(negedge clock);
    tlb_flush_one = 1'b1; tlb_flush_addr = 20'h00005;
    tlb_wvalid = 1'b1; tlb_awaddr = 20'h0000D; tlb_wdata = 20'h2222D;
    @(negedge clock);
    tlb_flush_one = 1'b0; tlb_wvalid = 1'b0;
    lookup_chk("fo_5", 20'h00005, 1'b0, 20'h0);
    lookup_chk("fo_D", 20'h0000D, 1'b0, 20'h0);
    lookup_chk("fo_9", 20'h00009, 1'b1, 20'h10009);

    // write visible to same-cycle lookup
    @(negedge clock);
    tlb_araddr = 20'h00002; tlb_rvalid = 1'b1;
    tlb_awaddr = 20'h00002; tlb_wdata = 20'h33332; tlb_wvalid = 1'b1;
    @(negedge clock);
    tlb_rvalid = 1'b0; tlb_wvalid = 1'b0;
    check_eq("rw_same_hit",   32'(tlb_hit),   32'd1);
    check_eq("rw_same_rdata", 32'(tlb_rdata), 32'h33332);

    // full flush with coincident write
    @(negedge clock);
    tlb_flush = 1'b1;
    tlb_wvalid = 1'b1; tlb_awaddr = 20'h00006; tlb_wdata = 20'h00006;
    @(negedge clock);
    tlb_flush = 1'b0; tlb_wvalid = 1'b0;
    lookup_chk("fl_9", 20'h00009, 1'b0, 20'h0);
    lookup_chk("fl_2", 20'h00002, 1'b0, 20'h0);
    lookup_chk("fl_6", 20'h00006, 1'b0, 20'h0);

    // reset coincident with a lookup suppresses rdone
    @(negedge clock);
    tlb_araddr = 20'h00009; tlb_rvalid = 1'b1; reset = 1'b1;
    @(negedge clock);
    tlb_rvalid = 1'b0; reset = 1'b0;
    check_eq("rst_mid_rdone", 32'(tlb_rdone), 32'd0);

`ifdef TLB_PERF_EN
    do_reset();
    do_write(20'h00005, 20'h0ABCD);
    lookup_chk("pc_h0", 20'h00005, 1'b1, 20'h0ABCD);
    lookup_chk("pc_m0", 20'h00009, 1'b0, 20'h0);
    lookup_chk("pc_h1", 20'h00005, 1'b1, 20'h0ABCD);
    lookup_chk("pc_m1", 20'h00009, 1'b0, 20'h0);
    lookup_chk("pc_h2", 20'h00005, 1'b1, 20'h0ABCD);
    @(negedge clock);
    check_eq("pc_hit_cnt",  tlb_hit_cnt,  32'd3);
    check_eq("pc_miss_cnt", tlb_miss_cnt, 32'd2);
    tlb_flush = 1'b1;
    @(negedge clock);
    tlb_flush = 1'b0;
    @(negedge clock);
    check_eq("pc_fl_hit",  tlb_hit_cnt,  32'd3);
    check_eq("pc_fl_miss", tlb_miss_cnt, 32'd2);
    do_reset();
    check_eq("pc_rst_hit",  tlb_hit_cnt,  32'd0);
    check_eq("pc_rst_miss", tlb_miss_cnt, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
